// File: rtl/zbb_seq.sv
// Sequential RISC-V Zbb execution unit: single-cycle ops finish the cycle after accept,
// clz/ctz/cpop scan CNT_STEP bits per cycle. Define ZBB_SEQ_CLMUL_EN to add iterative Zbc clmul/clmulr/clmulh.
module zbb_seq #(
    parameter int XLEN     = 32,
    parameter int CNT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] din_rs1,
    input  logic [XLEN-1:0] din_rs2,
    input  logic [6:0]      cmdOp,
    input  logic [2:0]      cmdF3,
    input  logic [6:0]      cmdF7,
    input  logic [11:0]     immI,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dout_rd,
    output logic            illegal
);

    localparam int SW    = $clog2(XLEN);
    localparam int CW    = SW + 1;
    localparam int N_CNT = XLEN / CNT_STEP;
    localparam logic [SW-1:0] CNT_LAST = SW'(N_CNT - 1);
    localparam logic [11:0]   REV8_IMM = (XLEN == 32) ? 12'h698 : 12'h6B8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [4:0] {
        OP_ANDN, OP_ORN, OP_XNOR, OP_MIN, OP_MINU, OP_MAX, OP_MAXU,
        OP_ROL, OP_ROR, OP_RORI, OP_CLZ, OP_CTZ, OP_CPOP, OP_SEXTB,
        OP_SEXTH, OP_ORCB, OP_REV8, OP_ZEXTH, OP_CLMUL, OP_CLMULR,
        OP_CLMULH, OP_ILL
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d, dec_op, op_s;
    logic [SW-1:0]     iter_q, iter_d;
    logic [XLEN-1:0]   scan_q, scan_d, scan_nx, src;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_nx, cnt_s, chunk_lz, chunk_pop;
    logic              found_q, found_d, found_nx, found_s;
    logic [XLEN-1:0]   dout_q, dout_d, single_res, rot_res, cnt_res, iter_res;
    logic              ill_q, ill_d;
    logic [XLEN-1:0]   rs1_rev, rev8_res, orcb_res;
    logic [SW-1:0]     sh_raw, sh_eff;
    logic [CNT_STEP-1:0] chunk;
    logic              busy, accept, rori_ok, dec_is_cnt;
`ifdef ZBB_SEQ_CLMUL_EN
    logic [2*XLEN-1:0] acc_q, acc_d, acc_nx, acc_s;
    logic [XLEN-1:0]   mcand_q, mcand_d, mcand_s, clmul_res;
    logic              dec_is_clmul, op_is_clmul;
`endif

    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = !rst && (state_q == DONE);
    assign illegal   = out_valid && ill_q;
    assign dout_rd   = dout_q;
    assign accept    = in_valid && in_ready && !kill;
    assign busy      = (state_q == BUSY);

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_bitrev
            assign rs1_rev[gi] = din_rs1[XLEN-1-gi];
        end
        for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_bytes
            assign rev8_res[8*gi +: 8] = din_rs1[XLEN-8-8*gi +: 8];
            assign orcb_res[8*gi +: 8] = {8{|din_rs1[8*gi +: 8]}};
        end
    endgenerate

    always_comb begin
        dec_op = OP_ILL;
        if (XLEN == 32) rori_ok = (immI[11:5] == 7'b0110000);
        else            rori_ok = (immI[11:6] == 6'b011000);
        if (cmdOp == 7'b0110011) begin
            case ({cmdF7, cmdF3})
                {7'b0100000, 3'b111}: dec_op = OP_ANDN;
                {7'b0100000, 3'b110}: dec_op = OP_ORN;
                {7'b0100000, 3'b100}: dec_op = OP_XNOR;
                {7'b0000101, 3'b100}: dec_op = OP_MIN;
                {7'b0000101, 3'b101}: dec_op = OP_MINU;
                {7'b0000101, 3'b110}: dec_op = OP_MAX;
                {7'b0000101, 3'b111}: dec_op = OP_MAXU;
                {7'b0110000, 3'b001}: dec_op = OP_ROL;
                {7'b0110000, 3'b101}: dec_op = OP_ROR;
                {7'b0000100, 3'b100}: dec_op = (immI[4:0] == 5'd0) ? OP_ZEXTH : OP_ILL;
`ifdef ZBB_SEQ_CLMUL_EN
                {7'b0000101, 3'b001}: dec_op = OP_CLMUL;
                {7'b0000101, 3'b010}: dec_op = OP_CLMULR;
                {7'b0000101, 3'b011}: dec_op = OP_CLMULH;
`endif
                default: dec_op = OP_ILL;
            endcase
        end else if (cmdOp == 7'b0010011) begin
            if (cmdF3 == 3'b001) begin
                case (immI)
                    12'h600: dec_op = OP_CLZ;
                    12'h601: dec_op = OP_CTZ;
                    12'h602: dec_op = OP_CPOP;
                    12'h604: dec_op = OP_SEXTB;
                    12'h605: dec_op = OP_SEXTH;
                    default: dec_op = OP_ILL;
                endcase
            end else if (cmdF3 == 3'b101) begin
                if (immI == 12'h287)       dec_op = OP_ORCB;
                else if (immI == REV8_IMM) dec_op = OP_REV8;
                else if (rori_ok)          dec_op = OP_RORI;
            end
        end
    end

    // Left rotation reuses the right rotator with the negated amount.
    always_comb begin
        sh_raw  = (dec_op == OP_RORI) ? immI[SW-1:0] : din_rs2[SW-1:0];
        sh_eff  = (dec_op == OP_ROL) ? (~sh_raw + SW'(1)) : sh_raw;
        rot_res = XLEN'({din_rs1, din_rs1} >> sh_eff);
    end

    always_comb begin
        single_res = '0;
        case (dec_op)
            OP_ANDN:  single_res = din_rs1 & ~din_rs2;
            OP_ORN:   single_res = din_rs1 | ~din_rs2;
            OP_XNOR:  single_res = ~(din_rs1 ^ din_rs2);
            OP_MIN:   single_res = ($signed(din_rs1) < $signed(din_rs2)) ? din_rs1 : din_rs2;
            OP_MINU:  single_res = (din_rs1 < din_rs2) ? din_rs1 : din_rs2;
            OP_MAX:   single_res = ($signed(din_rs1) < $signed(din_rs2)) ? din_rs2 : din_rs1;
            OP_MAXU:  single_res = (din_rs1 < din_rs2) ? din_rs2 : din_rs1;
            OP_ROL, OP_ROR, OP_RORI: single_res = rot_res;
            OP_SEXTB: single_res = {{(XLEN-8){din_rs1[7]}}, din_rs1[7:0]};
            OP_SEXTH: single_res = {{(XLEN-16){din_rs1[15]}}, din_rs1[15:0]};
            OP_ZEXTH: single_res = {{(XLEN-16){1'b0}}, din_rs1[15:0]};
            OP_ORCB:  single_res = orcb_res;
            OP_REV8:  single_res = rev8_res;
            default:  single_res = '0;
        endcase
    end

    // One scan step: on accept it works on fresh operands, in BUSY on the shifted copy.
    // ctz is handled as clz of the bit-reversed operand.
    always_comb begin
        op_s       = busy ? op_q : dec_op;
        dec_is_cnt = (dec_op == OP_CLZ) || (dec_op == OP_CTZ) || (dec_op == OP_CPOP);
        cnt_s      = busy ? cnt_q : '0;
        found_s    = busy && found_q;
        src        = busy ? scan_q : ((dec_op == OP_CTZ) ? rs1_rev : din_rs1);
`ifdef ZBB_SEQ_CLMUL_EN
        dec_is_clmul = (dec_op == OP_CLMUL) || (dec_op == OP_CLMULR) || (dec_op == OP_CLMULH);
        op_is_clmul  = (op_s == OP_CLMUL) || (op_s == OP_CLMULR) || (op_s == OP_CLMULH);
        if (!busy && dec_is_clmul) src = din_rs2;
`endif
        chunk     = src[XLEN-1 -: CNT_STEP];
        chunk_lz  = CW'(CNT_STEP);
        chunk_pop = '0;
        for (int i = 0; i < CNT_STEP; i++) begin
            if (chunk[i]) chunk_lz = CW'(CNT_STEP - 1 - i);
            chunk_pop = chunk_pop + CW'(chunk[i]);
        end
        cnt_nx   = cnt_s;
        found_nx = found_s;
        if (op_s == OP_CPOP) begin
            cnt_nx = cnt_s + chunk_pop;
        end else if (!found_s) begin
            cnt_nx   = cnt_s + chunk_lz;
            found_nx = (chunk != '0);
        end
        scan_nx = src << CNT_STEP;
        cnt_res = XLEN'(cnt_nx);
        iter_res = cnt_res;
`ifdef ZBB_SEQ_CLMUL_EN
        // Multiplier consumed MSB first: acc = (acc << 1) ^ (bit ? rs1 : 0).
        acc_s   = busy ? acc_q : '0;
        mcand_s = busy ? mcand_q : din_rs1;
        acc_nx  = (acc_s << 1) ^ {{XLEN{1'b0}}, mcand_s & {XLEN{src[XLEN-1]}}};
        if (op_is_clmul) scan_nx = src << 1;
        case (op_s)
            OP_CLMULH: clmul_res = acc_nx[2*XLEN-1:XLEN];
            OP_CLMULR: clmul_res = acc_nx[2*XLEN-2:XLEN-1];
            default:   clmul_res = acc_nx[XLEN-1:0];
        endcase
        if (op_is_clmul) iter_res = clmul_res;
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        iter_d  = iter_q;
        scan_d  = scan_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        dout_d  = dout_q;
        ill_d   = ill_q;
`ifdef ZBB_SEQ_CLMUL_EN
        acc_d   = acc_q;
        mcand_d = mcand_q;
`endif
        case (state_q)
            BUSY: begin
                scan_d  = scan_nx;
                cnt_d   = cnt_nx;
                found_d = found_nx;
`ifdef ZBB_SEQ_CLMUL_EN
                acc_d   = acc_nx;
`endif
                if (iter_q == SW'(1)) begin
                    state_d = DONE;
                    dout_d  = iter_res;
                    ill_d   = 1'b0;
                end else begin
                    iter_d = iter_q - SW'(1);
                end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d    = dec_op;
            ill_d   = (dec_op == OP_ILL);
            scan_d  = scan_nx;
            cnt_d   = cnt_nx;
            found_d = found_nx;
            state_d = DONE;
            dout_d  = single_res;
            if (dec_is_cnt) begin
                if (N_CNT == 1) begin
                    dout_d = cnt_res;
                end else begin
                    state_d = BUSY;
                    iter_d  = CNT_LAST;
                end
            end
`ifdef ZBB_SEQ_CLMUL_EN
            acc_d   = acc_nx;
            mcand_d = din_rs1;
            if (dec_is_clmul) begin
                state_d = BUSY;
                iter_d  = SW'(XLEN - 1);
            end
`endif
        end
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ILL;
            iter_q  <= '0;
            scan_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            dout_q  <= '0;
            ill_q   <= 1'b0;
`ifdef ZBB_SEQ_CLMUL_EN
            acc_q   <= '0;
            mcand_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            iter_q  <= iter_d;
            scan_q  <= scan_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            dout_q  <= dout_d;
            ill_q   <= ill_d;
`ifdef ZBB_SEQ_CLMUL_EN
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
`endif
        end
    end

endmodule

// File: tb/tb_zbb_seq.sv
// Scoreboard bench for zbb_seq (XLEN=32, CNT_STEP=4); driver pushes expectations, monitor checks outputs.
module tb_zbb_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din_rs1 = '0;
    logic [31:0] din_rs2 = '0;
    logic [6:0]  cmdOp = '0;
    logic [2:0]  cmdF3 = '0;
    logic [6:0]  cmdF7 = '0;
    logic [11:0] immI = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] dout_rd;
    logic        illegal;

    typedef struct {
        string       name;
        logic [31:0] dout;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_ready = 1'b0;
    bit   done_req = 1'b0;

    zbb_seq #(.XLEN(32), .CNT_STEP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din_rs1(din_rs1), .din_rs2(din_rs2), .cmdOp(cmdOp), .cmdF3(cmdF3),
        .cmdF7(cmdF7), .immI(immI), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .dout_rd(dout_rd), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got no end of run, want finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] imm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_i, input int lat,
                         input bit push);
        exp_t e;
        int   w;
        cmdOp = op; cmdF3 = f3; cmdF7 = f7; immI = imm;
        din_rs1 = a; din_rs2 = b; in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !kill) break;
            w++;
            if (w > 200) begin
                $display("FAIL issue_timeout %s: got in_ready=0 for 200 cycles, want 1", nm);
                $fatal(1, "issue timeout");
            end
        end
        step();
        in_valid = 1'b0;
        din_rs1 = $urandom; din_rs2 = $urandom; immI = 12'($urandom);
        if (push) begin
            e.name = nm; e.dout = exp_d; e.ill = exp_i; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic do_op(input string nm, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_i, input int lat);
        issue(nm, 7'b0110011, f3, f7, {f7, 5'd0}, a, b, exp_d, exp_i, lat, 1'b1);
    endtask

    task automatic do_opi(input string nm, input logic [2:0] f3, input logic [11:0] imm,
                          input logic [31:0] a, input logic [31:0] exp_d, input int lat);
        issue(nm, 7'b0010011, f3, imm[11:5], imm, a, 32'h0, exp_d, 1'b0, lat, 1'b1);
    endtask

    // Monitor: all comparisons happen here, sampled on the falling edge.
    initial begin
        exp_t e;
        int   lat_meas;
        bit   presented;
        presented = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc != 0) begin
                if (rst) begin
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b0 || illegal !== 1'b0 || dout_rd !== 32'h0) begin
                        errors++;
                        $display("FAIL reset_outputs: got rdy=%b vld=%b ill=%b dout=%h, want all 0",
                                 in_ready, out_valid, illegal, dout_rd);
                    end
                end
                if (chk_ready) begin
                    checks++;
                    if (in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL ready_after_abort: got in_ready=%b, want 1", in_ready);
                    end
                end
                if (!rst && out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: got dout=%h ill=%b, want no output", dout_rd, illegal);
                    end else begin
                        e = sb[0];
                        if (!presented) begin
                            presented = 1'b1;
                            lat_meas = cyc - e.acc + 1;
                            checks++;
                            if (lat_meas != e.lat) begin
                                errors++;
                                $display("FAIL %s_latency: got %0d cycles, want %0d", e.name, lat_meas, e.lat);
                            end
                        end
                        checks++;
                        if (!out_ready) begin
                            if (dout_rd !== e.dout || illegal !== e.ill || in_ready !== 1'b0) begin
                                errors++;
                                $display("FAIL %s_hold: got dout=%h ill=%b rdy=%b, want dout=%h ill=%b rdy=0",
                                         e.name, dout_rd, illegal, in_ready, e.dout, e.ill);
                            end
                        end else begin
                            if (dout_rd !== e.dout || illegal !== e.ill) begin
                                errors++;
                                $display("FAIL %s: got dout=%h ill=%b, want dout=%h ill=%b",
                                         e.name, dout_rd, illegal, e.dout, e.ill);
                            end else begin
                                $display("txn %-8s dout=%h ill=%b", e.name, dout_rd, illegal);
                            end
                            sb.delete(0);
                            presented = 1'b0;
                        end
                    end
                end
                if (done_req) begin
                    checks++;
                    if (sb.size() != 0) begin
                        errors++;
                        $display("FAIL pending_results: got %0d outstanding, want 0", sb.size());
                    end
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
        end
    end

    initial begin
        int w;
        repeat (3) step();
        rst = 1'b0;
        chk_ready = 1'b1;
        step();
        chk_ready = 1'b0;

        // Counting ops
        do_opi("clz",    3'b001, 12'h600, 32'h00010000, 32'd15, 8);
        do_opi("cpop",   3'b001, 12'h602, 32'hFFFFFFFF, 32'd32, 8);
        do_opi("ctz0",   3'b001, 12'h601, 32'h00000000, 32'd32, 8);
        do_opi("ctz31",  3'b001, 12'h601, 32'h80000000, 32'd31, 8);
        do_opi("clz0",   3'b001, 12'h600, 32'h00000000, 32'd32, 8);
        do_opi("clzmsb", 3'b001, 12'h600, 32'h80000000, 32'd0,  8);
        do_opi("cpop9",  3'b001, 12'h602, 32'h0F0F0001, 32'd9,  8);
        do_opi("ctz8",   3'b001, 12'h601, 32'h00000100, 32'd8,  8);

        // Single-cycle ops
        do_opi("rori4",  3'b101, 12'h604, 32'h12345678, 32'h81234567, 1);
        do_opi("rori0",  3'b101, 12'h600, 32'h12345678, 32'h12345678, 1);
        do_op("rol",  7'b0110000, 3'b001, 32'h12345678, 32'h00000024, 32'h23456781, 1'b0, 1);
        do_op("ror",  7'b0110000, 3'b101, 32'h12345678, 32'h00000008, 32'h78123456, 1'b0, 1);
        do_op("min",  7'b0000101, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1);
        do_op("minu", 7'b0000101, 3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
        do_op("max",  7'b0000101, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
        do_op("maxu", 7'b0000101, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1);
        do_op("xnor", 7'b0100000, 3'b100, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 1'b0, 1);
        do_op("zexth", 7'b0000100, 3'b100, 32'hFFFF1234, 32'h0, 32'h00001234, 1'b0, 1);
        do_opi("sextb", 3'b001, 12'h604, 32'h00000080, 32'hFFFFFF80, 1);
        do_opi("sexth", 3'b001, 12'h605, 32'h00008000, 32'hFFFF8000, 1);
        do_opi("orcb",  3'b101, 12'h287, 32'h00010200, 32'h00FFFF00, 1);
        do_opi("rev8",  3'b101, 12'h698, 32'h12345678, 32'h78563412, 1);

        // Illegal encodings
        do_op("illop", 7'b1111111, 3'b000, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b1, 1);
        issue("illimm", 7'b0010011, 3'b001, 7'b0110000, 12'h603, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 1'b1);

`ifdef ZBB_SEQ_CLMUL_EN
        do_op("clmul",  7'b0000101, 3'b001, 32'd3, 32'd3, 32'd5, 1'b0, 32);
        do_op("clmulh", 7'b0000101, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 32);
        do_op("clmulr", 7'b0000101, 3'b010, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 32);
`else
        do_op("clmul",  7'b0000101, 3'b001, 32'd3, 32'd3, 32'h0, 1'b1, 1);
        do_op("clmulh", 7'b0000101, 3'b011, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 1);
        do_op("clmulr", 7'b0000101, 3'b010, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 1);
`endif

        // Result held under back-pressure, then back-to-back accept on release
        repeat (2) step();
        out_ready = 1'b0;
        do_op("andn", 7'b0100000, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0, 1);
        repeat (5) step();
        out_ready = 1'b1;
        do_op("orn",  7'b0100000, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0FFF0FF, 1'b0, 1);
        repeat (3) step();

        // kill three cycles into cpop: no result, ready next cycle
        issue("cpopk", 7'b0010011, 3'b001, 7'b0110000, 12'h602, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 8, 1'b0);
        repeat (2) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk_ready = 1'b1;
        step();
        chk_ready = 1'b0;
        repeat (12) step();

        // kill wins over a same-cycle request
        cmdOp = 7'b0010011; cmdF3 = 3'b001; immI = 12'h600; din_rs1 = 32'h1;
        kill = 1'b1; in_valid = 1'b1;
        step();
        kill = 1'b0; in_valid = 1'b0;
        repeat (12) step();

        // reset in the middle of clz discards it
        issue("clzr", 7'b0010011, 3'b001, 7'b0110000, 12'h600, 32'h1, 32'h0, 32'h0, 1'b0, 8, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk_ready = 1'b1;
        step();
        chk_ready = 1'b0;
        repeat (12) step();

        do_opi("clzpost", 3'b001, 12'h600, 32'h00000001, 32'd31, 8);

        w = 0;
        while (sb.size() != 0 && w < 300) begin
            step();
            w++;
        end
        repeat (3) step();
        done_req = 1'b1;
    end

endmodule
